pipelined_control_unit: RTL

Next-generation RV32I control path. Decodes opcode/funct3/funct7 in Decode and carries the control bundle through pipeline registers into the Execute, Memory and Writeback stages. Resolves branches and jumps in Execute from the datapath comparison flags. Applies hazard-unit flush and bubble requests, and reports the branch-taken redirect.

---
 rtl/pipelined_control_unit.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipelined_control_unit.sv
// RV32I control path: decodes in D and carries the control bundle through E, M and W.
// Define CTRL_ILLEGAL_EN to add the illegal_W output that flags unsupported encodings in W.
module pipelined_control_unit #(
    parameter int unsigned ALU_CTRL_W   = 4,
    parameter int unsigned RESULT_SEL_W = 2,
    parameter int unsigned IMM_SEL_W    = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              opcode,
    input  logic [2:0]              funct3,
    input  logic [6:0]              funct7,
    input  logic                    flush_E,
    input  logic                    zero_E,
    input  logic                    lt_E,
    input  logic                    ltu_E,
    output logic [IMM_SEL_W-1:0]    sel_imm_D,
    output logic [ALU_CTRL_W-1:0]   ctrl_ALU_E,
    output logic                    ctrl_srcB_E,
    output logic                    ctrl_srcA_pc_E,
    output logic                    jalr_E,
    output logic                    pc_src_E,
    output logic                    ctrl_data_memory_WE_M,
    output logic [RESULT_SEL_W-1:0] ctrl_result_M,
    output logic                    ctrl_register_file_WE_M,
    output logic                    ctrl_register_file_WE_W,
    output logic [RESULT_SEL_W-1:0] ctrl_result_W
`ifdef CTRL_ILLEGAL_EN
    ,
    output logic                    illegal_W
`endif
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    localparam logic [ALU_CTRL_W-1:0] AluAdd   = ALU_CTRL_W'(4'd0);
    localparam logic [ALU_CTRL_W-1:0] AluSub   = ALU_CTRL_W'(4'd1);
    localparam logic [ALU_CTRL_W-1:0] AluAnd   = ALU_CTRL_W'(4'd2);
    localparam logic [ALU_CTRL_W-1:0] AluOr    = ALU_CTRL_W'(4'd3);
    localparam logic [ALU_CTRL_W-1:0] AluXor   = ALU_CTRL_W'(4'd4);
    localparam logic [ALU_CTRL_W-1:0] AluSlt   = ALU_CTRL_W'(4'd5);
    localparam logic [ALU_CTRL_W-1:0] AluSll   = ALU_CTRL_W'(4'd6);
    localparam logic [ALU_CTRL_W-1:0] AluSrl   = ALU_CTRL_W'(4'd7);
    localparam logic [ALU_CTRL_W-1:0] AluSra   = ALU_CTRL_W'(4'd8);
    localparam logic [ALU_CTRL_W-1:0] AluSltu  = ALU_CTRL_W'(4'd9);
    localparam logic [ALU_CTRL_W-1:0] AluPassB = ALU_CTRL_W'(4'd10);

    localparam logic [RESULT_SEL_W-1:0] ResMem = RESULT_SEL_W'(2'd1);
    localparam logic [RESULT_SEL_W-1:0] ResPc4 = RESULT_SEL_W'(2'd2);

    localparam logic [IMM_SEL_W-1:0] ImmI = IMM_SEL_W'(3'd0);
    localparam logic [IMM_SEL_W-1:0] ImmS = IMM_SEL_W'(3'd1);
    localparam logic [IMM_SEL_W-1:0] ImmB = IMM_SEL_W'(3'd2);
    localparam logic [IMM_SEL_W-1:0] ImmJ = IMM_SEL_W'(3'd3);
    localparam logic [IMM_SEL_W-1:0] ImmU = IMM_SEL_W'(3'd4);

    // All-zero bundle is the bubble: add, ALU result, no enables, no branch/jump.
    typedef struct packed {
        logic [ALU_CTRL_W-1:0]   alu;
        logic                    src_b_imm;
        logic                    src_a_pc;
        logic                    jalr;
        logic                    branch;
        logic                    jump;
        logic [2:0]              funct3;
        logic                    rf_we;
        logic                    dm_we;
        logic [RESULT_SEL_W-1:0] result;
    } ctrl_t;

    ctrl_t                   dec;
    ctrl_t                   ctrl_E_q;
    logic                    r_funct7_ok;
    logic                    br_cond;
    logic                    rf_we_M_q;
    logic                    dm_we_M_q;
    logic [RESULT_SEL_W-1:0] result_M_q;
    logic                    rf_we_W_q;
    logic [RESULT_SEL_W-1:0] result_W_q;

    function automatic logic [ALU_CTRL_W-1:0] alu_op(input logic [2:0] f3, input logic alt,
                                                     input logic is_r);
        case (f3)
            3'b000:  alu_op = (is_r && alt) ? AluSub : AluAdd;
            3'b001:  alu_op = AluSll;
            3'b010:  alu_op = AluSlt;
            3'b011:  alu_op = AluSltu;
            3'b100:  alu_op = AluXor;
            3'b101:  alu_op = alt ? AluSra : AluSrl;
            3'b110:  alu_op = AluOr;
            default: alu_op = AluAnd;
        endcase
    endfunction

    assign r_funct7_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

    always_comb begin
        dec       = '0;
        sel_imm_D = ImmI;
        case (opcode)
            OpR: begin
                if (r_funct7_ok) begin
                    dec.rf_we = 1'b1;
                    dec.alu   = alu_op(funct3, funct7[5], 1'b1);
                end
            end
            OpImm: begin
                dec.rf_we     = 1'b1;
                dec.src_b_imm = 1'b1;
                dec.alu       = alu_op(funct3, funct7[5], 1'b0);
            end
            OpLoad: begin
                dec.rf_we     = 1'b1;
                dec.src_b_imm = 1'b1;
                dec.result    = ResMem;
            end
            OpStore: begin
                dec.dm_we     = 1'b1;
                dec.src_b_imm = 1'b1;
                sel_imm_D     = ImmS;
            end
            OpBranch: begin
                dec.branch = 1'b1;
                dec.funct3 = funct3;
                dec.alu    = AluSub;
                sel_imm_D  = ImmB;
            end
            OpJal, OpJalr: begin
                dec.jump      = 1'b1;
                dec.jalr      = (opcode == OpJalr);
                dec.rf_we     = 1'b1;
                dec.src_b_imm = 1'b1;
                dec.src_a_pc  = 1'b1;
                dec.result    = ResPc4;
                sel_imm_D     = (opcode == OpJal) ? ImmJ : ImmI;
            end
            OpLui: begin
                dec.rf_we     = 1'b1;
                dec.src_b_imm = 1'b1;
                dec.alu       = AluPassB;
                sel_imm_D     = ImmU;
            end
            default: ;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (ctrl_E_q.funct3)
            3'b000:  br_cond = zero_E;
            3'b001:  br_cond = !zero_E;
            3'b100:  br_cond = lt_E;
            3'b101:  br_cond = !lt_E;
            3'b110:  br_cond = ltu_E;
            3'b111:  br_cond = !ltu_E;
            default: br_cond = 1'b0;
        endcase
    end

    assign pc_src_E = ctrl_E_q.jump | (ctrl_E_q.branch & br_cond);

    // A redirect squashes the instruction in D; the E instruction itself still moves to M.
    always_ff @(posedge clk) begin
        if (reset || flush_E || pc_src_E) begin
            ctrl_E_q <= '0;
        end else begin
            ctrl_E_q <= dec;
        end
        if (reset) begin
            rf_we_M_q  <= 1'b0;
            dm_we_M_q  <= 1'b0;
            result_M_q <= '0;
            rf_we_W_q  <= 1'b0;
            result_W_q <= '0;
        end else begin
            rf_we_M_q  <= ctrl_E_q.rf_we;
            dm_we_M_q  <= ctrl_E_q.dm_we;
            result_M_q <= ctrl_E_q.result;
            rf_we_W_q  <= rf_we_M_q;
            result_W_q <= result_M_q;
        end
    end

`ifdef CTRL_ILLEGAL_EN
    logic illegal_D;
    logic illegal_E_q;
    logic illegal_M_q;
    logic illegal_W_q;

    assign illegal_D = !(opcode inside {OpR, OpImm, OpLoad, OpStore, OpBranch, OpJal, OpJalr,
                                        OpLui}) || ((opcode == OpR) && !r_funct7_ok);

    always_ff @(posedge clk) begin
        if (reset || flush_E || pc_src_E) begin
            illegal_E_q <= 1'b0;
        end else begin
            illegal_E_q <= illegal_D;
        end
        if (reset) begin
            illegal_M_q <= 1'b0;
            illegal_W_q <= 1'b0;
        end else begin
            illegal_M_q <= illegal_E_q;
            illegal_W_q <= illegal_M_q;
        end
    end

    assign illegal_W = illegal_W_q;
`endif

    assign ctrl_ALU_E              = ctrl_E_q.alu;
    assign ctrl_srcB_E             = ctrl_E_q.src_b_imm;
    assign ctrl_srcA_pc_E          = ctrl_E_q.src_a_pc;
    assign jalr_E                  = ctrl_E_q.jalr;
    assign ctrl_data_memory_WE_M   = dm_we_M_q;
    assign ctrl_result_M           = result_M_q;
    assign ctrl_register_file_WE_M = rf_we_M_q;
    assign ctrl_register_file_WE_W = rf_we_W_q;
    assign ctrl_result_W           = result_W_q;

endmodule
